// File: rtl/gpio_link_pkg.sv
// Shared types and constants for the pulpino <-> USB GPIO byte link.
// Optional build macro GPIO_WORD_TX_ARB_TAG_EN prefixes every word with a tag byte.
package gpio_link_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_B, END, WAIT_W, DONE
  } arb_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [4:0] TAG_PREFIX = 5'b10100;

  // gpio_out / gpio_in bit positions
  localparam int DATA_LSB = 0;
  localparam int USB_RD   = 8;
  localparam int USB_WR   = 9;
  localparam int EXT_RD   = 10;
  localparam int EXT_WR   = 11;

`ifdef GPIO_WORD_TX_ARB_TAG_EN
  localparam int WORD_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int WORD_BYTES = BYTES_PER_WORD;
`endif

  // Tag byte identifying the word's source requester
  function automatic logic [7:0] tag_byte(input logic [2:0] idx);
    return {TAG_PREFIX, idx};
  endfunction

endpackage

// File: rtl/gpio_word_tx_arbiter_flicker_event_det.sv
// flicker_event_det: 2-FF synchroniser plus toggle-to-pulse for a peer flicker line.
// The history register tracks the synchronised level every cycle, including
// during reset, so leaving reset never produces a spurious event.
module flicker_event_det (
  input  logic clk,
  input  logic rst,
  input  logic flicker,
  output logic evt
);

  logic [1:0] sync;
  logic       hist;

  // Synchroniser chain; no reset so it always tracks the pin
  always_ff @(posedge clk) begin
    sync <= {sync[0], flicker};
  end

  // History follows the synchronised level unconditionally
  always_ff @(posedge clk) begin
    hist <= sync[1];
  end

  assign evt = (sync[1] ^ hist) & ~rst;

endmodule

// File: rtl/gpio_word_tx_arbiter.sv
// gpio_word_tx_arbiter: round-robin owner of the GPIO byte channel; serialises
// a 32-bit word into flicker-handshaked bytes followed by an end-of-word flicker.
// Build macro: GPIO_WORD_TX_ARB_TAG_EN sends {10100, owner} before the data bytes.
module gpio_word_tx_arbiter
  import gpio_link_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_word,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_err,
  output logic [NUM_REQ-1:0]       grant,
  output logic [7:0]               out_data,
  output logic                     byte_write_flicker,
  output logic                     word_write_flicker,
  input  logic                     byte_read_flicker,
  input  logic                     word_read_flicker
);

  localparam int SHW = 8 * WORD_BYTES;

  arb_state_e       state, nxt;
  logic [SHW-1:0]   shift;
  logic [2:0]       byte_cnt;
  logic [2:0]       owner, rr_ptr, pick_idx;
  logic             pick_found;
  logic [31:0]      tmo_cnt;
  logic [31:0]      sel_word;
  logic             byte_evt, word_evt, tmo_hit;

  flicker_event_det u_byte_ack (.clk(clk), .rst(rst), .flicker(byte_read_flicker), .evt(byte_evt));
  flicker_event_det u_word_ack (.clk(clk), .rst(rst), .flicker(word_read_flicker), .evt(word_evt));

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: first valid index at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(idx);
      end
    end
  end

  // Owner's word mux
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner == 3'(i)) sel_word = req_word[i];
  end

  // Next-state logic; an ack beats a same-cycle timeout
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (pick_found) nxt = LOAD;
      LOAD:    nxt = SEND;
      SEND:    nxt = WAIT_B;
      WAIT_B:  if (byte_evt) nxt = (byte_cnt == 3'(WORD_BYTES - 1)) ? END : SEND;
               else if (tmo_hit) nxt = DONE;
      END:     nxt = WAIT_W;
      WAIT_W:  if (word_evt || tmo_hit) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      grant              <= '0;
      owner              <= '0;
      rr_ptr             <= '0;
      shift              <= '0;
      byte_cnt           <= '0;
      tmo_cnt            <= '0;
      out_data           <= '0;
      byte_write_flicker <= 1'b0;
      word_write_flicker <= 1'b0;
      req_done           <= '0;
      req_err            <= 1'b0;
    end else begin
      state    <= nxt;
      req_done <= '0;
      req_err  <= 1'b0;
      unique case (state)
        IDLE: if (pick_found) begin
          owner <= pick_idx;
          grant <= NUM_REQ'(1) << pick_idx;
        end
        LOAD: begin
`ifdef GPIO_WORD_TX_ARB_TAG_EN
          shift <= {tag_byte(owner), sel_word};
`else
          shift <= sel_word;
`endif
          byte_cnt <= '0;
        end
        SEND: begin
          out_data           <= shift[SHW-1 -: 8];
          byte_write_flicker <= ~byte_write_flicker;
          tmo_cnt            <= '0;
        end
        WAIT_B: begin
          if (byte_evt) begin
            shift    <= shift << 8;
            byte_cnt <= byte_cnt + 3'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        END: begin
          word_write_flicker <= ~word_write_flicker;
          tmo_cnt            <= '0;
        end
        WAIT_W: tmo_cnt <= tmo_cnt + 32'd1;
        DONE: begin
          grant  <= '0;
          rr_ptr <= (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
        end
        default: ;
      endcase
      // Completion pulse is visible while the FSM sits in DONE
      if ((state == WAIT_B || state == WAIT_W) && nxt == DONE) begin
        req_done <= grant;
        req_err  <= !(state == WAIT_W && word_evt);
      end
    end
  end

endmodule
